// File: rtl/seq_min_max_pkg.sv
// Shared types for the sequence min/max tracker: FSM state encoding and
// the comparison mode selected by the SIGNED_MODE parameter.
package seq_min_max_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef enum logic {
    CMP_UNSIGNED = 1'b0,
    CMP_SIGNED   = 1'b1
  } cmp_mode_t;

  function automatic cmp_mode_t cmp_mode_of(input int signed_mode);
    return (signed_mode != 0) ? CMP_SIGNED : CMP_UNSIGNED;
  endfunction

endpackage

// File: rtl/minmax_cmp.sv
// Combinational magnitude compare of i_a against i_b, producing strict
// greater-than and less-than flags in unsigned or two's-complement mode.
module minmax_cmp
  import seq_min_max_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SIGNED_MODE = 0
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_gt,
  output logic              o_lt
);

  localparam cmp_mode_t MODE = cmp_mode_of(SIGNED_MODE);

  always_comb begin
    if (MODE == CMP_SIGNED) begin
      o_gt = $signed(i_a) > $signed(i_b);
      o_lt = $signed(i_a) < $signed(i_b);
    end else begin
      o_gt = i_a > i_b;
      o_lt = i_a < i_b;
    end
  end

endmodule

// File: rtl/seq_min_max.sv
// Tracks the largest and smallest sample (with earliest 0-based index) of a
// framed sample sequence; results are registered and flagged by a done pulse.
module seq_min_max
  import seq_min_max_pkg::*;
#(
  parameter int  DATA_W      = 8,
  parameter int  SIGNED_MODE = 0,
  parameter int  MAX_LEN     = 16,
  localparam int CNT_W       = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              valid,
  input  logic              last,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] max_value,
  output logic [DATA_W-1:0] min_value,
  output logic [CNT_W-1:0]  max_index,
  output logic [CNT_W-1:0]  min_index,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  // Handshake: a sample is taken on a rising edge where valid=1 while in
  // COLLECT and start=0; there is no backpressure, so the producer never stalls.

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_busy;
  logic               r_done;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [DATA_W-1:0]  r_max;
  logic [DATA_W-1:0]  r_min;
  logic [CNT_W-1:0]   r_max_idx;
  logic [CNT_W-1:0]   r_min_idx;
  logic [CNT_W-1:0]   r_count;
  logic               w_accept;
  logic               w_final;
  logic               w_max_gt;
  logic               w_min_lt;
  logic               w_max_lt_unused;
  logic               w_min_gt_unused;

  assign w_accept = (r_state == COLLECT) && valid && !start;
  assign w_final  = w_accept && (last || (r_count == CNT_W'(MAX_LEN - 1)));

  minmax_cmp #(
    .DATA_W      (DATA_W),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_cmp_max (
    .i_a  (data_in),
    .i_b  (r_max),
    .o_gt (w_max_gt),
    .o_lt (w_max_lt_unused)
  );

  minmax_cmp #(
    .DATA_W      (DATA_W),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_cmp_min (
    .i_a  (data_in),
    .i_b  (r_min),
    .o_gt (w_min_gt_unused),
    .o_lt (w_min_lt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // start wins in every state: it restarts a running sequence without a done.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = COLLECT;
      COLLECT: begin
        if (start)        w_state_nxt = COLLECT;
        else if (w_final) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = start ? COLLECT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt == COLLECT);
    w_done_nxt = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max     <= '0;
      r_min     <= '0;
      r_max_idx <= '0;
      r_min_idx <= '0;
      r_count   <= '0;
    end else if (start) begin
      r_max     <= '0;
      r_min     <= '0;
      r_max_idx <= '0;
      r_min_idx <= '0;
      r_count   <= '0;
    end else if (w_accept) begin
      // The first sample seeds both trackers; later ones replace only on a
      // strict win so ties keep the earliest index.
      if (r_count == '0) begin
        r_max     <= data_in;
        r_min     <= data_in;
        r_max_idx <= '0;
        r_min_idx <= '0;
      end else begin
        if (w_max_gt) begin
          r_max     <= data_in;
          r_max_idx <= r_count;
        end
        if (w_min_lt) begin
          r_min     <= data_in;
          r_min_idx <= r_count;
        end
      end
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign max_value = r_max;
  assign min_value = r_min;
  assign max_index = r_max_idx;
  assign min_index = r_min_idx;
  assign count     = r_count;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_min_max.sv
// Directed bench for seq_min_max: unsigned, signed and short-MAX_LEN
// instances share one stimulus stream; results are checked by scoreboard.
module tb_seq_min_max;
  import seq_min_max_pkg::*;

  localparam int RW = 31;

  logic       clk;
  logic       reset;
  logic       start;
  logic       valid;
  logic       last;
  logic [7:0] data_in;

  logic [7:0] mx_u, mn_u, mx_s, mn_s, mx_m, mn_m;
  logic [4:0] mxi_u, mni_u, cnt_u, mxi_s, mni_s, cnt_s;
  logic [2:0] mxi_m, mni_m, cnt_m;
  logic       busy_u, done_u, busy_s, done_s, busy_m, done_m;
  state_t     st_u, st_s, st_m;

  logic [RW-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_done_u = 0;
  int d0;

  seq_min_max #(.DATA_W(8), .SIGNED_MODE(0), .MAX_LEN(16)) u_dut_u (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .last(last),
    .data_in(data_in), .max_value(mx_u), .min_value(mn_u), .max_index(mxi_u),
    .min_index(mni_u), .count(cnt_u), .busy(busy_u), .done(done_u),
    .dbg_state(st_u)
  );

  seq_min_max #(.DATA_W(8), .SIGNED_MODE(1), .MAX_LEN(16)) u_dut_s (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .last(last),
    .data_in(data_in), .max_value(mx_s), .min_value(mn_s), .max_index(mxi_s),
    .min_index(mni_s), .count(cnt_s), .busy(busy_s), .done(done_s),
    .dbg_state(st_s)
  );

  seq_min_max #(.DATA_W(8), .SIGNED_MODE(0), .MAX_LEN(4)) u_dut_m (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .last(last),
    .data_in(data_in), .max_value(mx_m), .min_value(mn_m), .max_index(mxi_m),
    .min_index(mni_m), .count(cnt_m), .busy(busy_m), .done(done_m),
    .dbg_state(st_m)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done_u === 1'b1) n_done_u++;

  function automatic logic [RW-1:0] pk(input logic [7:0] mx, input logic [7:0] mn,
                                       input logic [4:0] mxi, input logic [4:0] mni,
                                       input logic [4:0] cnt);
    return {mx, mn, mxi, mni, cnt};
  endfunction

  function automatic logic [RW-1:0] get_res(input int sel);
    case (sel)
      0:       return pk(mx_u, mn_u, mxi_u, mni_u, cnt_u);
      1:       return pk(mx_s, mn_s, mxi_s, mni_s, cnt_s);
      default: return pk(mx_m, mn_m, {2'b00, mxi_m}, {2'b00, mni_m}, {2'b00, cnt_m});
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // driver: present inputs for one rising edge, then release
  task automatic step(input logic s, input logic v, input logic l, input logic [7:0] d);
    start = s; valid = v; last = l; data_in = d;
    @(posedge clk);
    #1;
    start = 1'b0; valid = 1'b0; last = 1'b0;
  endtask

  task automatic check_result(input int sel, input string tag);
    if (exp_q.size() == 0) begin
      n_chk++;
      $error("FAIL %s observed=none expected=queued result", tag);
    end else begin
      chk(tag, 32'(get_res(sel)), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_res_u", 32'(get_res(0)), 32'd0);
    chk("reset_busy_done", {30'd0, busy_u, done_u}, 32'd0);
    chk("reset_state", 32'(st_u), 32'(IDLE));
    reset = 1'b0;

    // unsigned basic with tie on max
    step(1, 0, 0, 8'd0);
    chk("start_busy", 32'(busy_u), 32'd1);
    chk("start_count", 32'(cnt_u), 32'd0);
    exp_q.push_back(pk(8'd200, 8'd3, 5'd1, 5'd2, 5'd4));
    d0 = n_done_u;
    step(0, 1, 0, 8'd5);
    step(0, 1, 0, 8'd200);
    step(0, 1, 0, 8'd3);
    chk("mid_res", 32'(get_res(0)), 32'(pk(8'd200, 8'd3, 5'd1, 5'd2, 5'd3)));
    chk("mid_done_low", 32'(done_u), 32'd0);
    step(0, 1, 1, 8'd200);
    chk("basic_done", {30'd0, done_u, busy_u}, 32'd2);
    check_result(0, "basic_res");
    step(0, 1, 1, 8'd99);
    chk("basic_done_once", 32'(done_u), 32'd0);
    chk("basic_hold", 32'(get_res(0)), 32'(pk(8'd200, 8'd3, 5'd1, 5'd2, 5'd4)));
    chk("basic_done_count", 32'(n_done_u - d0), 32'd1);

    // signed vs unsigned compare of the same stream
    step(1, 0, 0, 8'd0);
    exp_q.push_back(pk(8'h7F, 8'h80, 5'd0, 5'd1, 5'd3));
    exp_q.push_back(pk(8'h80, 8'h00, 5'd1, 5'd2, 5'd3));
    step(0, 1, 0, 8'h7F);
    step(0, 1, 0, 8'h80);
    step(0, 1, 1, 8'h00);
    chk("signed_done", 32'(done_s), 32'd1);
    check_result(1, "signed_res");
    check_result(0, "unsigned_res");

    // forced end at MAX_LEN=4, later samples ignored
    step(0, 0, 0, 8'd0);
    step(1, 0, 0, 8'd0);
    exp_q.push_back(pk(8'd40, 8'd10, 5'd3, 5'd0, 5'd4));
    step(0, 1, 0, 8'd10);
    step(0, 1, 0, 8'd20);
    step(0, 1, 0, 8'd30);
    chk("maxlen_early", 32'(done_m), 32'd0);
    step(0, 1, 0, 8'd40);
    chk("maxlen_done", 32'(done_m), 32'd1);
    check_result(2, "maxlen_res");
    step(0, 1, 0, 8'd50);
    step(0, 1, 0, 8'd60);
    chk("maxlen_ignored", 32'(get_res(2)), 32'(pk(8'd40, 8'd10, 5'd3, 5'd0, 5'd4)));
    chk("maxlen_idle", {30'd0, done_m, busy_m}, 32'd0);
    chk("unsig_six", 32'(get_res(0)), 32'(pk(8'd60, 8'd10, 5'd5, 5'd0, 5'd6)));

    // restart mid-sequence with a discarded sample
    d0 = n_done_u;
    step(1, 0, 0, 8'd0);
    step(0, 1, 0, 8'd50);
    step(0, 1, 0, 8'd60);
    chk("abort_pre", 32'(cnt_u), 32'd2);
    step(1, 1, 0, 8'd0);
    chk("abort_clear", 32'(get_res(0)), 32'd0);
    chk("abort_busy", {30'd0, busy_u, done_u}, 32'd2);
    chk("abort_no_done", 32'(n_done_u - d0), 32'd0);
    exp_q.push_back(pk(8'd9, 8'd1, 5'd0, 5'd1, 5'd2));
    step(0, 1, 0, 8'd9);
    step(0, 1, 1, 8'd1);
    chk("abort_done", 32'(done_u), 32'd1);
    check_result(0, "abort_res");

    // gaps in valid
    step(1, 0, 0, 8'd0);
    exp_q.push_back(pk(8'd10, 8'd4, 5'd0, 5'd1, 5'd2));
    step(0, 1, 0, 8'd10);
    step(0, 0, 0, 8'd77);
    step(0, 0, 1, 8'd0);
    chk("gap_hold", 32'(get_res(0)), 32'(pk(8'd10, 8'd10, 5'd0, 5'd0, 5'd1)));
    step(0, 1, 1, 8'd4);
    chk("gap_done", 32'(done_u), 32'd1);
    check_result(0, "gap_res");

    // start during the DONE cycle
    step(1, 0, 0, 8'd0);
    step(0, 1, 1, 8'd7);
    chk("dstart_done", 32'(done_u), 32'd1);
    d0 = n_done_u;
    step(1, 0, 0, 8'd0);
    chk("dstart_pulse", 32'(n_done_u - d0), 32'd1);
    chk("dstart_collect", {30'd0, busy_u, done_u}, 32'd2);
    chk("dstart_clear", 32'(get_res(0)), 32'd0);
    exp_q.push_back(pk(8'd8, 8'd8, 5'd0, 5'd0, 5'd1));
    step(0, 1, 1, 8'd8);
    check_result(0, "dstart_res");

    // asynchronous reset mid-sequence
    step(0, 0, 0, 8'd0);
    step(1, 0, 0, 8'd0);
    step(0, 1, 0, 8'd21);
    step(0, 1, 0, 8'd22);
    d0 = n_done_u;
    #3 reset = 1'b1;
    #1;
    chk("areset_res", 32'(get_res(0)), 32'd0);
    chk("areset_flags", {30'd0, busy_u, done_u}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    step(0, 1, 1, 8'd5);
    chk("areset_ignored", 32'(get_res(0)), 32'd0);
    chk("areset_no_done", 32'(n_done_u - d0), 32'd0);
    step(1, 0, 0, 8'd0);
    exp_q.push_back(pk(8'd33, 8'd11, 5'd0, 5'd1, 5'd2));
    step(0, 1, 0, 8'd33);
    step(0, 1, 1, 8'd11);
    chk("areset_done", 32'(done_u), 32'd1);
    check_result(0, "areset_res2");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_min_max.md
SEQ_MIN_MAX -- requirements
Module: seq_min_max

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample width in bits.
REQ-002 SHALL have parameter SIGNED_MODE, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 SHALL have parameter MAX_LEN, default 16, maximum samples per sequence (range 2..65535).
REQ-004 SHALL have derived localparam CNT_W = clog2(MAX_LEN+1).
REQ-005 SHALL have port clk, input, 1, single clock; all flops rise-edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1, begins a new sequence.
REQ-008 SHALL have port valid, input, 1, data_in carries a sample this cycle.
REQ-009 SHALL have port last, input, 1, qualified by valid; marks the final sample.
REQ-010 SHALL have port data_in, input, DATA_W, sample value.
REQ-011 SHALL have port max_value, output, DATA_W, largest sample so far.
REQ-012 SHALL have port min_value, output, DATA_W, smallest sample so far.
REQ-013 SHALL have port max_index, output, CNT_W, 0-based position of max_value.
REQ-014 SHALL have port min_index, output, CNT_W, 0-based position of min_value.
REQ-015 SHALL have port count, output, CNT_W, samples accepted in current/last sequence.
REQ-016 SHALL have port busy, output, 1, high while in COLLECT.
REQ-017 SHALL have port done, output, 1, one-cycle pulse when results are final.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, DONE.
REQ-019 SHALL move IDLE->COLLECT on start; clear count, indices, max/min to 0 that same edge.
REQ-020 SHALL, in COLLECT, accept one sample per cycle where valid=1; valid=0 cycles leave all state unchanged.
REQ-021 SHALL load the first accepted sample (count=0) into both max_value and min_value, indices 0.
REQ-022 SHALL update max_value/max_index only when sample is strictly greater; ties keep earliest index.
REQ-023 SHALL update min_value/min_index only when sample is strictly less; ties keep earliest index.
REQ-024 SHALL compare per SIGNED_MODE; no widening or saturation of stored values.
REQ-025 SHALL increment count per accepted sample; new value visible the cycle after acceptance.
REQ-026 SHALL move COLLECT->DONE on accepted sample with last=1, or when count reaches MAX_LEN (forced end, last ignored).
REQ-027 SHALL assert done for exactly the DONE cycle, then return to IDLE; results final and stable when done=1.
REQ-028 SHALL hold all result outputs in IDLE until the next start.
REQ-029 SHALL ignore valid/last in IDLE and DONE.
REQ-030 SHALL, on start in COLLECT, abort and restart (clear as REQ-019) with no done pulse; a valid sample that same cycle is discarded.
REQ-031 SHALL, on start in DONE, still pulse done and enter COLLECT next (clear as REQ-019).
REQ-032 SHALL produce done one cycle after the final sample's acceptance edge.

Reset
REQ-033 SHALL, on reset asserted at any time including mid-sequence, force state IDLE and all outputs to 0 (done=0, busy=0) asynchronously.
REQ-034 SHALL resume normal operation on the first clk edge after reset deasserts.

Structure
REQ-035 SHALL place the FSM state enum and a compare-mode enum in shared package seq_min_max_pkg.
REQ-036 SHALL instantiate sub-module minmax_cmp (parametrised DATA_W, SIGNED_MODE; combinational gt/lt flags) once for max and once for min.
REQ-037 SHALL register all outputs; no combinational input-to-output paths.

Verification
REQ-038 Unsigned, DATA_W=8: start, samples 5,200,3,200,last=1 -> done once; max=200 idx1, min=3 idx2, count=4.
REQ-039 SIGNED_MODE=1: samples 0x7F,0x80,0x00 last -> max=0x7F idx0, min=0x80 idx1.
REQ-040 MAX_LEN=4: six valid samples, no last -> done after 4th; count=4; samples 5,6 ignored.
REQ-041 Mid-sequence start after 2 samples, then 9,1 last -> no done before restart; max=9, min=1, count=2.
REQ-042 reset asserted between clk edges mid-COLLECT -> outputs 0 immediately; no done; next start works.
REQ-043 Gaps: valid toggled 1,0,0,1(last) with values 10,x,x,4 -> count=2, max=10 idx0, min=4 idx1.
